// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: EX/MEM op -> word-aligned data-cache request -> raw load word held for WB.
// Latency: accept -> rsp_valid is 2 cycles minimum (zero-wait cache), more with gnt/rvalid delays; stores end at gnt.
// Backpressure: req_ready only in IDLE; dc_req held until dc_gnt; rsp_* held until rsp_ready; optional watchdog abort.
// Build option MEM_MISALIGN_TRAP_EN: adds misalign_err/misalign_addr and traps misaligned ops instead of issuing them.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_load_type,
  input  logic [1:0]  req_store_type,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        dc_req,
  output logic [31:0] dc_addr,
  output logic [3:0]  dc_we,
  output logic [31:0] dc_wdata,
  input  logic        dc_gnt,
  input  logic        dc_rvalid,
  input  logic [31:0] dc_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_addr,
  output logic [2:0]  rsp_load_type,
  output logic [4:0]  rsp_rd,
  output logic        busy,
  output logic        timeout_err
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign_err,
  output logic [31:0] misalign_addr
`endif
);

  // Load-type encodings shared with the WB load extender
  localparam logic [2:0] LT_NOREGWRITE = 3'd0;
  localparam logic [2:0] LT_LB         = 3'd1;
  localparam logic [2:0] LT_LH         = 3'd2;
  localparam logic [2:0] LT_LW         = 3'd3;
  localparam logic [2:0] LT_LBU        = 3'd4;
  localparam logic [2:0] LT_LHU        = 3'd5;

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_SB   = 2'b01;
  localparam logic [1:0] ST_SH   = 2'b10;
  localparam logic [1:0] ST_SW   = 2'b11;

  // Counter value seen in the last permitted REQ/WAIT cycle
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t      state_q;
  logic        req_ready_q, busy_q, dc_req_q, rsp_valid_q, timeout_err_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  we_q;
  logic [2:0]  ltype_q;
  logic [4:0]  rd_q;
  logic        is_load_q;
  logic [CNT_W-1:0] cnt_q;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_err_q;
  logic [31:0] misalign_addr_q;
  logic        in_mis;
`endif

  logic        in_load, in_store, in_ld_mis, in_st_mis, in_go;
  logic [3:0]  in_we;
  logic [31:0] in_wdata;
  logic        wd_hit;

  // Classify the offered op, detect misalignment and build lane-aligned store data/enables
  always_comb begin
    in_load  = (req_load_type != LT_NOREGWRITE);
    in_store = !in_load && (req_store_type != ST_NONE);

    in_ld_mis = 1'b0;
    case (req_load_type)
      LT_LH, LT_LHU: in_ld_mis = req_addr[0];
      LT_LW:         in_ld_mis = |req_addr[1:0];
      default:       in_ld_mis = 1'b0;
    endcase

    in_st_mis = 1'b0;
    in_we     = 4'b0000;
    in_wdata  = req_wdata;
    case (req_store_type)
      ST_SB: begin
        in_we    = 4'b0001 << req_addr[1:0];
        in_wdata = {4{req_wdata[7:0]}};
      end
      ST_SH: begin
        in_we     = 4'b0011 << {req_addr[1], 1'b0};
        in_wdata  = {2{req_wdata[15:0]}};
        in_st_mis = req_addr[0];
      end
      ST_SW: begin
        in_we     = 4'b1111;
        in_st_mis = |req_addr[1:0];
      end
      default: in_we = 4'b0000;
    endcase
    // Loads take priority over any store type carried alongside and never write
    if (in_load) in_we = 4'b0000;

`ifdef MEM_MISALIGN_TRAP_EN
    in_mis = in_load ? in_ld_mis : (in_store & in_st_mis);
    in_go  = (in_load | in_store) & ~in_mis;
`else
    // Misaligned loads still go out; the WB extender sees the original offset
    in_go  = in_load | (in_store & ~in_st_mis);
`endif
  end

  assign wd_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TO_LAST));

  // Sequencer FSM with all outputs registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      req_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      dc_req_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      we_q          <= '0;
      ltype_q       <= '0;
      rd_q          <= '0;
      is_load_q     <= 1'b0;
      cnt_q         <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_err_q  <= 1'b0;
      misalign_addr_q <= '0;
`endif
    end else begin
      timeout_err_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_err_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready_q) begin
            addr_q    <= req_addr;
            wdata_q   <= in_wdata;
            we_q      <= in_we;
            ltype_q   <= req_load_type;
            rd_q      <= req_rd;
            is_load_q <= in_load;
            if (in_go) begin
              state_q     <= S_REQ;
              req_ready_q <= 1'b0;
              busy_q      <= 1'b1;
              dc_req_q    <= 1'b1;
              cnt_q       <= '0;
            end
`ifdef MEM_MISALIGN_TRAP_EN
            if (in_mis) begin
              misalign_err_q  <= 1'b1;
              misalign_addr_q <= req_addr;
            end
`endif
          end
        end
        S_REQ: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (dc_gnt) begin
            dc_req_q <= 1'b0;
            if (!is_load_q) begin
              state_q     <= S_IDLE;
              busy_q      <= 1'b0;
              req_ready_q <= 1'b1;
            end else if (dc_rvalid) begin
              rdata_q     <= dc_rdata;
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
            end else if (wd_hit) begin
              rdata_q       <= '0;
              timeout_err_q <= 1'b1;
              state_q       <= S_RESP;
              rsp_valid_q   <= 1'b1;
            end else begin
              state_q <= S_WAIT;
            end
          end else if (wd_hit) begin
            dc_req_q      <= 1'b0;
            timeout_err_q <= 1'b1;
            if (is_load_q) begin
              rdata_q     <= '0;
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q     <= S_IDLE;
              busy_q      <= 1'b0;
              req_ready_q <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (dc_rvalid) begin
            rdata_q     <= dc_rdata;
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
          end else if (wd_hit) begin
            rdata_q       <= '0;
            timeout_err_q <= 1'b1;
            state_q       <= S_RESP;
            rsp_valid_q   <= 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          dc_req_q    <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign busy          = busy_q;
  assign dc_req        = dc_req_q;
  assign dc_addr       = {addr_q[31:2], 2'b00};
  assign dc_we         = we_q;
  assign dc_wdata      = wdata_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rdata_q;
  assign rsp_addr      = addr_q[1:0];
  assign rsp_load_type = ltype_q;
  assign rsp_rd        = rd_q;
  assign timeout_err   = timeout_err_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_err  = misalign_err_q;
  assign misalign_addr = misalign_addr_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver pushes expected cache requests and load responses,
// a negedge monitor compares them plus per-cycle handshake/status windows.
// Random ops come from a high-level model of alignment, lane replication and load/store priority.
module tb_mem_access_unit;

  localparam int TO = 10;
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam logic [2:0] LB = 3'd1, LH = 3'd2, LW = 3'd3, LBU = 3'd4, LHU = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_load_type;
  logic [1:0]  req_store_type;
  logic [4:0]  req_rd;
  logic        dc_req, dc_gnt, dc_rvalid;
  logic [31:0] dc_addr, dc_wdata, dc_rdata;
  logic [3:0]  dc_we;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_addr;
  logic [2:0]  rsp_load_type;
  logic [4:0]  rsp_rd;
  logic        busy, timeout_err;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_err;
  logic [31:0] misalign_addr;
`endif

  mem_access_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_load_type(req_load_type), .req_store_type(req_store_type),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .dc_req(dc_req), .dc_addr(dc_addr), .dc_we(dc_we), .dc_wdata(dc_wdata),
    .dc_gnt(dc_gnt), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_load_type(rsp_load_type), .rsp_rd(rsp_rd),
    .busy(busy), .timeout_err(timeout_err)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign_err(misalign_err), .misalign_addr(misalign_addr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        is_store;
  } cache_exp_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  addr;
    logic [2:0]  lt;
    logic [4:0]  rd;
  } rsp_exp_t;

  cache_exp_t exp_cache[$];
  rsp_exp_t   exp_rsp[$];

  int n_chk = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;
  // Expected status of the current cycle, set by the driver right after each edge
  bit win_busy = 1'b0, win_req = 1'b0, win_rsp = 1'b0, win_to = 1'b0, win_mis = 1'b0;
  logic [31:0] exp_mis_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: 1=load, 2=store, 0=no-op; misalignment by access size; lane placement by arithmetic
  function automatic void model(input logic [2:0] lt, input logic [1:0] st, input logic [31:0] a,
                                input logic [31:0] b, output int kind, output bit mis,
                                output logic [3:0] we, output logic [31:0] wd);
    int off;
    off  = int'(a % 4);
    kind = 0; mis = 1'b0; we = 4'd0; wd = b;
    if (lt != 3'd0) begin
      kind = 1;
      if (lt == LH || lt == LHU) mis = (off % 2) != 0;
      else if (lt == LW)         mis = off != 0;
    end else if (st != 2'd0) begin
      kind = 2;
      if (st == 2'd1) begin
        we = 4'(1 << off);
        wd = (b & 32'hFF) * 32'h0101_0101;
      end else if (st == 2'd2) begin
        mis = (off % 2) != 0;
        we  = 4'(3 << (off - (off % 2)));
        wd  = (b & 32'hFFFF) * 32'h0001_0001;
      end else begin
        mis = off != 0;
        we  = 4'hF;
      end
    end
  endfunction

  task automatic finish_rsp(input int stall);
    repeat (stall) tick;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    win_rsp = 1'b0; win_busy = 1'b0;
  endtask

  // gdel<0: never grant; rvdel<0: never return data (both exercise the watchdog)
  task automatic do_op(input logic [2:0] lt, input logic [1:0] st, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input int gdel,
                       input int rvdel, input int stall, input logic [31:0] rdat);
    int kind, used;
    bit mis, go;
    logic [3:0] we;
    logic [31:0] wd;
    model(lt, st, a, b, kind, mis, we, wd);
    go = (kind == 1 && !(TRAP && mis)) || (kind == 2 && !mis);
    req_valid = 1'b1; req_load_type = lt; req_store_type = st;
    req_addr = a; req_wdata = b; req_rd = rd;
    tick;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_load_type = 3'($urandom_range(0, 7)); req_store_type = 2'($urandom_range(0, 3));
    req_rd = 5'($urandom_range(0, 31));
    if (!go) begin
      if (TRAP && mis && kind != 0) begin
        win_mis = 1'b1; exp_mis_addr = a;
      end
      tick;
      win_mis = 1'b0;
      return;
    end
    exp_cache.push_back('{addr: a & 32'hFFFF_FFFC, we: we, wdata: wd, is_store: (kind == 2)});
    win_busy = 1'b1; win_req = 1'b1;
    if (gdel < 0) begin
      repeat (TO) tick;
      void'(exp_cache.pop_front());
      win_req = 1'b0; win_to = 1'b1;
      if (kind == 1) begin
        exp_rsp.push_back('{data: 32'd0, addr: a[1:0], lt: lt, rd: rd});
        win_rsp = 1'b1;
      end else win_busy = 1'b0;
      tick;
      win_to = 1'b0;
      if (kind == 1) finish_rsp(stall);
      return;
    end
    // rvalid before the grant must be ignored
    repeat (gdel) begin
      dc_rvalid = 1'($urandom_range(0, 1)); dc_rdata = $urandom;
      tick;
    end
    dc_gnt = 1'b1; dc_rvalid = 1'b0;
    if (kind == 1 && rvdel == 0) begin dc_rvalid = 1'b1; dc_rdata = rdat; end
    tick;
    dc_gnt = 1'b0; dc_rvalid = 1'b0; dc_rdata = $urandom;
    win_req = 1'b0; used = gdel + 1;
    if (kind == 2) begin
      win_busy = 1'b0;
      tick;
      return;
    end
    if (rvdel == 0) begin
      exp_rsp.push_back('{data: rdat, addr: a[1:0], lt: lt, rd: rd});
      win_rsp = 1'b1;
      finish_rsp(stall);
      return;
    end
    if (rvdel < 0) begin
      repeat (TO - used) tick;
      exp_rsp.push_back('{data: 32'd0, addr: a[1:0], lt: lt, rd: rd});
      win_rsp = 1'b1; win_to = 1'b1;
      tick;
      win_to = 1'b0;
      finish_rsp(stall);
      return;
    end
    repeat (rvdel - 1) tick;
    dc_rvalid = 1'b1; dc_rdata = rdat;
    tick;
    dc_rvalid = 1'b0; dc_rdata = $urandom;
    exp_rsp.push_back('{data: rdat, addr: a[1:0], lt: lt, rd: rd});
    win_rsp = 1'b1;
    finish_rsp(stall);
  endtask

  // Monitor: per-cycle status windows plus scoreboard pops on each handshake
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", 32'(busy), 32'(win_busy));
      chk("req_ready", 32'(req_ready), 32'(!win_busy));
      chk("dc_req", 32'(dc_req), 32'(win_req));
      chk("rsp_valid", 32'(rsp_valid), 32'(win_rsp));
      chk("timeout_err", 32'(timeout_err), 32'(win_to));
`ifdef MEM_MISALIGN_TRAP_EN
      chk("misalign_err", 32'(misalign_err), 32'(win_mis));
      if (win_mis) chk("misalign_addr", misalign_addr, exp_mis_addr);
`endif
      if (dc_req) begin
        if (exp_cache.size() == 0) chk("dc_req_unexpected", 32'(dc_req), 32'd0);
        else begin
          chk("dc_addr", dc_addr, exp_cache[0].addr);
          chk("dc_we", 32'(dc_we), 32'(exp_cache[0].we));
          if (exp_cache[0].is_store) chk("dc_wdata", dc_wdata, exp_cache[0].wdata);
          if (dc_gnt) void'(exp_cache.pop_front());
        end
      end
      if (rsp_valid) begin
        if (exp_rsp.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        else begin
          chk("rsp_data", rsp_data, exp_rsp[0].data);
          chk("rsp_addr", 32'(rsp_addr), 32'(exp_rsp[0].addr));
          chk("rsp_load_type", 32'(rsp_load_type), 32'(exp_rsp[0].lt));
          chk("rsp_rd", 32'(rsp_rd), 32'(exp_rsp[0].rd));
          if (rsp_ready) void'(exp_rsp.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0;
    req_load_type = '0; req_store_type = '0; req_rd = '0;
    dc_gnt = 1'b0; dc_rvalid = 1'b1; dc_rdata = 32'hDEAD_BEEF; rsp_ready = 1'b1;
    repeat (3) tick;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dc_req", 32'(dc_req), 32'd0);
    chk("rst_dc_addr", dc_addr, 32'd0);
    chk("rst_dc_we", 32'(dc_we), 32'd0);
    chk("rst_dc_wdata", dc_wdata, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_rd", 32'(rsp_rd), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    dc_rvalid = 1'b0; rsp_ready = 1'b0;
    rst_n = 1'b1; mon_en = 1'b1;
    tick;

    // SB to byte 3, grant in the second REQ cycle
    do_op(3'd0, 2'b01, 32'h0000_1003, 32'h0000_00A5, 5'd0, 1, 0, 0, 32'h0);
    // LHU with zero-wait cache, WB stalls three cycles
    do_op(LHU, 2'b00, 32'h0000_2002, 32'h0, 5'd7, 0, 0, 3, 32'hBEEF_1234);
    // LW with data five cycles after the grant
    do_op(LW, 2'b00, 32'h0000_3000, 32'h0, 5'd9, 0, 5, 1, 32'h1234_5678);
    // Watchdog: load never granted, store never granted, load granted but no data
    do_op(LW, 2'b00, 32'h0000_5000, 32'h0, 5'd3, -1, 0, 1, 32'h0);
    do_op(3'd0, 2'b11, 32'h0000_5004, 32'hCAFE_F00D, 5'd0, -1, 0, 0, 32'h0);
    do_op(LB, 2'b00, 32'h0000_5009, 32'h0, 5'd4, 2, -1, 0, 32'h0);
    // Misaligned SW, no-op, load carrying a store type, SH upper half
    do_op(3'd0, 2'b11, 32'h0000_4002, 32'h1111_2222, 5'd0, 0, 0, 0, 32'h0);
    do_op(3'd0, 2'b00, 32'h0000_6000, 32'h0, 5'd1, 0, 0, 0, 32'h0);
    do_op(LBU, 2'b11, 32'h0000_7001, 32'h5555_AAAA, 5'd31, 0, 2, 0, 32'h8765_4321);
    do_op(3'd0, 2'b10, 32'h0000_8002, 32'h0000_BEEF, 5'd0, 0, 0, 0, 32'h0);

    // Reset during WAIT; a late rvalid must not revive the op
    req_valid = 1'b1; req_load_type = LW; req_store_type = 2'b00;
    req_addr = 32'h0000_9000; req_rd = 5'd5;
    tick;
    req_valid = 1'b0;
    exp_cache.push_back('{addr: 32'h0000_9000, we: 4'd0, wdata: 32'd0, is_store: 1'b0});
    win_busy = 1'b1; win_req = 1'b1;
    dc_gnt = 1'b1;
    tick;
    dc_gnt = 1'b0; win_req = 1'b0;
    tick;
    rst_n = 1'b0; win_busy = 1'b0;
    repeat (2) tick;
    rst_n = 1'b1; dc_rvalid = 1'b1; dc_rdata = 32'hFFFF_0000;
    tick;
    dc_rvalid = 1'b0;
    repeat (2) tick;

    // Randomized mix
    for (int i = 0; i < 60; i++) begin
      logic [2:0] lt;
      lt = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 5));
      do_op(lt, 2'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom_range(0, 31)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
            $urandom);
    end

    repeat (3) tick;
    mon_en = 1'b0;
    chk("cache_queue_drained", 32'(exp_cache.size()), 32'd0);
    chk("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
